muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter DATA_W, default 32, operand and HI/LO width; legal values 8..64 and even.
REQ-002 Parameter MUL_LAT, default 2, multiply latency in cycles; legal range 1..4.
REQ-003 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1, reset; asynchronous, active-low.
REQ-005 Port start_i, input, 1, request to issue op_i with a_i and b_i this cycle.
REQ-006 Port op_i, input, 3, operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB.
REQ-007 Port a_i, input, DATA_W, rs operand and dividend.
REQ-008 Port b_i, input, DATA_W, rt operand and divisor.
REQ-009 Port cancel_i, input, 1, pipeline flush; aborts the operation in flight.
REQ-010 Port busy_o, output, 1, multi-cycle operation in flight; drives the pipeline stall.
REQ-011 Port done_o, output, 1, one-cycle pulse when HI/LO take a new mul/div/madd result.
REQ-012 Port hi_o, output, DATA_W, architectural HI register.
REQ-013 Port lo_o, output, DATA_W, architectural LO register.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, MUL and DIV.
REQ-015 In IDLE, start_i=1 with cancel_i=0 SHALL be accepted at edge E0.
REQ-016 While busy_o=1, start_i SHALL be ignored.
REQ-017 MULT/MULTU SHALL enter MUL and produce the full 2*DATA_W product, signed or unsigned per op.
REQ-018 For MULT/MULTU/MADD/MSUB, HI/LO SHALL update, done_o SHALL rise and busy_o SHALL fall at edge E0+MUL_LAT.
REQ-019 DIV/DIVU SHALL enter DIV: DATA_W radix-2 restoring iterations plus 1 sign-fixup cycle; HI/LO update, done_o rises and busy_o falls at edge E0+DATA_W+1.
REQ-020 DIV result: LO=quotient, HI=remainder; the remainder takes the sign of the dividend; the quotient is negative iff operand signs differ.
REQ-021 Signed most-negative / -1 SHALL give LO=most-negative, HI=0.
REQ-022 Divide by zero SHALL take normal latency and give LO=all-ones, HI=a_i.
REQ-023 MTHI/MTLO SHALL write a_i into HI/LO at E0, stay in IDLE, and assert neither busy_o nor done_o.
REQ-024 busy_o SHALL be 1 exactly while the FSM is in MUL or DIV.
REQ-025 done_o SHALL be high for exactly one cycle per completed operation.
REQ-026 cancel_i=1 while busy SHALL return the FSM to IDLE at the next edge with HI/LO unchanged and no done_o.
REQ-027 cancel_i=1 with start_i=1 in IDLE SHALL discard the request.
REQ-028 Operands SHALL be captured at E0; input changes after E0 SHALL NOT affect the result.

Reset
REQ-029 Asserting rst SHALL immediately force IDLE, hi_o=0, lo_o=0, busy_o=0 and done_o=0, including mid-operation.
REQ-030 Deassertion SHALL be synchronised internally; the first start_i SHALL be accepted no earlier than the second edge after deassertion.

Configuration
REQ-031 Macro MULDIV_MADD_EN defined: MADD sets {HI,LO} += signed a*b and MSUB sets {HI,LO} -= signed a*b, both modulo 2^(2*DATA_W), with MUL timing.
REQ-032 Macro MULDIV_MADD_EN undefined: op 110/111 SHALL be no-ops with no busy_o, no done_o and HI/LO unchanged, and no accumulator adder SHALL be synthesised.

Structure
REQ-033 Package muldiv_pkg SHALL hold the op_i encoding constants and the FSM state type.
REQ-034 The divide iteration datapath (magnitudes, partial remainder, quotient shift, fixup) SHALL be sub-module div_iter; the multiply pipeline stays in muldiv_unit.

Verification
REQ-035 MULT a=0xFFFFFFFE (-2), b=3, MUL_LAT=2 -> done_o at E0+2, HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-036 DIV a=-7, b=2 -> busy_o for 33 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=7, b=0 -> LO=0xFFFFFFFF, HI=7.
REQ-037 DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-038 DIV started with HI=0x11, then cancel_i at E0+10 -> busy_o=0 after the next edge, HI=0x11, no done_o; a new start_i is accepted on the following cycle.
REQ-039 With MULDIV_MADD_EN: MTHI 0, MTLO 0xFFFFFFFF, then MADD a=1, b=1 -> HI=1, LO=0; without the macro the same MADD -> HI/LO unchanged and no busy_o.
REQ-040 rst asserted mid-DIV at E0+5 -> all outputs 0 immediately; start_i in the cycle of deassertion is ignored.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op_i encodings, FSM state type and signedness helper for muldiv_unit.
package muldiv_pkg;
   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [2:0] OP_MADD  = 3'b110;
   localparam logic [2:0] OP_MSUB  = 3'b111;

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

   function automatic logic op_signed(input logic [2:0] op);
      return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
   endfunction
endpackage

// File: rtl/muldiv_unit_div_iter.sv
// div_iter: radix-2 restoring divider on operand magnitudes with a final sign fixup.
module div_iter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         step_i,
   input  logic         sgn_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] q_o,
   output logic [W-1:0] r_o
);
   logic [W-1:0] q_q, r_q, d_q;
   logic         neg_q_q, neg_r_q, dz_q;
   logic [W:0]   rs, diff;

   assign rs   = {r_q, q_q[W-1]};
   assign diff = rs - {1'b0, d_q};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q     <= '0;
         r_q     <= '0;
         d_q     <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         dz_q    <= 1'b0;
      end else if (load_i) begin
         q_q     <= sgn_i && a_i[W-1] ? -a_i : a_i;
         d_q     <= sgn_i && b_i[W-1] ? -b_i : b_i;
         r_q     <= '0;
         neg_q_q <= sgn_i && (a_i[W-1] ^ b_i[W-1]);
         neg_r_q <= sgn_i && a_i[W-1];
         dz_q    <= b_i == '0;
      end else if (step_i) begin
         r_q <= diff[W] ? rs[W-1:0] : diff[W-1:0];
         q_q <= {q_q[W-2:0], ~diff[W]};
      end
   end

   // a zero divisor leaves |a| as remainder, so only the quotient needs forcing
   assign q_o = dz_q ? '1 : neg_q_q ? -q_q : q_q;
   assign r_o = neg_r_q ? -r_q : r_q;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply/divide unit with pipeline cancel.
// Define MULDIV_MADD_EN to enable the MADD/MSUB accumulate ops.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int MUL_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [2:0]        op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              cancel_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);
   localparam int CW = $clog2(DATA_W + 1);

   state_e              state_q, state_d;
   logic [1:0]          rdy_q;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [2:0]          op_q;
   logic [DATA_W-1:0]   a_q, b_q, hi_q, hi_d, lo_q, lo_d, dq, dr;
   logic                done_q, done_d, accept, mul_op, div_op, sg, dload, dstep;
   logic [2*DATA_W-1:0] ax, bx, prod, acc;

   assign accept = state_q == IDLE && start_i && !cancel_i && rdy_q[1];
   assign div_op = op_i inside {OP_DIV, OP_DIVU};
   assign sg     = op_signed(op_q);
   assign ax     = {{DATA_W{sg & a_q[DATA_W-1]}}, a_q};
   assign bx     = {{DATA_W{sg & b_q[DATA_W-1]}}, b_q};
   assign prod   = ax * bx;
`ifdef MULDIV_MADD_EN
   assign mul_op = op_i inside {OP_MULT, OP_MULTU, OP_MADD, OP_MSUB};
   assign acc    = op_q == OP_MADD ? {hi_q, lo_q} + prod :
                   op_q == OP_MSUB ? {hi_q, lo_q} - prod : prod;
`else
   assign mul_op = op_i inside {OP_MULT, OP_MULTU};
   assign acc    = prod;
`endif

   div_iter #(.W(DATA_W)) u_div (
      .clk   (clk),
      .rst   (rst),
      .load_i(dload),
      .step_i(dstep),
      .sgn_i (op_signed(op_i)),
      .a_i   (a_i),
      .b_i   (b_i),
      .q_o   (dq),
      .r_o   (dr)
   );

   // start_i is honoured only once the released reset has crossed two flops
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdy_q   <= '0;
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         rdy_q   <= {rdy_q[0], 1'b1};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         if (accept) begin
            op_q <= op_i;
            a_q  <= a_i;
            b_q  <= b_i;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dload   = 1'b0;
      dstep   = 1'b0;
      case (state_q)
         IDLE: if (accept) begin
            if (op_i == OP_MTHI) hi_d = a_i;
            else if (op_i == OP_MTLO) lo_d = a_i;
            else if (mul_op) begin
               state_d = MUL;
               cnt_d   = CW'(MUL_LAT - 1);
            end else if (div_op) begin
               state_d = DIV;
               cnt_d   = CW'(DATA_W);
               dload   = 1'b1;
            end
         end
         MUL: if (cancel_i) state_d = IDLE;
            else if (cnt_q == '0) begin
               state_d      = IDLE;
               done_d       = 1'b1;
               {hi_d, lo_d} = acc;
            end else cnt_d = cnt_q - 1'b1;
         DIV: if (cancel_i) state_d = IDLE;
            else if (cnt_q == '0) begin
               state_d = IDLE;
               done_d  = 1'b1;
               hi_d    = dr;
               lo_d    = dq;
            end else begin
               dstep = 1'b1;
               cnt_d = cnt_q - 1'b1;
            end
         default: state_d = IDLE;
      endcase
   end

   assign busy_o = state_q != IDLE;
   assign done_o = done_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit checked against an arithmetic reference model.
module tb_muldiv_unit;
   import muldiv_pkg::*;
   localparam int W = 32;
   localparam int L = 2;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a, b, hi, lo;
   } vec_t;

   logic         clk = 1'b0, rst = 1'b1, start_i = 1'b0, cancel_i = 1'b0;
   logic [2:0]   op_i = '0;
   logic [W-1:0] a_i = '0, b_i = '0;
   logic         busy_o, done_o;
   logic [W-1:0] hi_o, lo_o;
   int           errors = 0, checks = 0, nb;
   vec_t         tv [12];

   muldiv_unit #(.DATA_W(W), .MUL_LAT(L)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
      .cancel_i(cancel_i), .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   function automatic void check(string n, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", n, act, exp);
      end
   endfunction

   // reference model: results computed at issue, released after the op's latency
   logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   logic         m_busy = 1'b0, m_done = 1'b0;
   int           cyc = 0, m_end = 0, since_rst = 0;

   task automatic sched(input logic [2*W-1:0] p, input int lat);
      {p_hi, p_lo} = p;
      m_busy = 1'b1;
      m_end  = cyc + lat;
   endtask

   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] sp, up;
      logic [W-1:0]   q, r;
      int             sa, sb;
      sp = 64'(longint'($signed(a)) * longint'($signed(b)));
      up = {32'b0, a} * {32'b0, b};
      sa = a;
      sb = b;
      if (b == '0) begin
         q = '1;
         r = a;
      end else if (op == OP_DIV && a == 32'h8000_0000 && b == '1) begin
         q = a;
         r = '0;
      end else if (op == OP_DIV) begin
         q = sa / sb;
         r = sa % sb;
      end else begin
         q = a / b;
         r = a % b;
      end
      case (op)
         OP_MTHI:  m_hi = a;
         OP_MTLO:  m_lo = a;
         OP_MULT:  sched(sp, L);
         OP_MULTU: sched(up, L);
         OP_DIV, OP_DIVU: sched({r, q}, W + 1);
`ifdef MULDIV_MADD_EN
         OP_MADD:  sched({m_hi, m_lo} + sp, L);
         OP_MSUB:  sched({m_hi, m_lo} - sp, L);
`endif
         default: ;
      endcase
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; since_rst = 0;
      end else begin
         m_done = 1'b0;
         if (m_busy) begin
            if (cancel_i) m_busy = 1'b0;
            else if (cyc == m_end) begin
               m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; m_busy = 1'b0;
            end
         end else if (start_i && !cancel_i && since_rst >= 2) issue(op_i, a_i, b_i);
         cyc++;
         since_rst++;
      end
   end

   always @(negedge clk) begin
      check("cyc_busy", busy_o, m_busy);
      check("cyc_done", done_o, m_done);
      check("cyc_hi", hi_o, m_hi);
      check("cyc_lo", lo_o, m_lo);
   end

   task automatic pulse(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      start_i = 1'b1; op_i = op; a_i = a; b_i = b;
      @(negedge clk);
      start_i = 1'b0; op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      for (int k = 0; k < 60 && !done_o; k++) begin
         n += int'(busy_o);
         @(negedge clk);
      end
      check("done_timeout", done_o, 1);
   endtask

   task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int n);
      pulse(op, a, b);
      wait_done(n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tv = '{
         '{OP_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA},
         '{OP_MULTU, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA},
         '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD},
         '{OP_DIVU,  32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF},
         '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000},
         '{OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF},
         '{OP_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E},
         '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD},
         '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
         '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001},
         '{OP_DIVU,  32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF},
         '{OP_DIV,   32'h8000_0000, 32'd1,         32'h0000_0000, 32'h8000_0000}
      };
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_hi", hi_o, 0);
      check("rst_lo", lo_o, 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      foreach (tv[i]) begin
         do_op(tv[i].op, tv[i].a, tv[i].b, nb);
         check($sformatf("vec%0d_lat", i), nb, tv[i].op[1] ? W + 1 : L);
         check($sformatf("vec%0d_hi", i), hi_o, tv[i].hi);
         check($sformatf("vec%0d_lo", i), lo_o, tv[i].lo);
      end

      pulse(OP_MTHI, 32'h11, 0);
      check("mthi_hi", hi_o, 32'h11);
      check("mthi_busy", busy_o, 0);
      pulse(OP_DIVU, 32'd100, 32'd7);
      pulse(OP_MTHI, 32'h99, 0);
      wait_done(nb);
      check("ignored_start_hi", hi_o, 32'h2);
      check("ignored_start_lo", lo_o, 32'd14);

      pulse(OP_MTHI, 32'h11, 0);
      pulse(OP_DIV, 32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      cancel_i = 1'b1;
      @(negedge clk);
      cancel_i = 1'b0;
      check("cancel_busy", busy_o, 0);
      check("cancel_done", done_o, 0);
      check("cancel_hi", hi_o, 32'h11);
      start_i = 1'b1; op_i = OP_MULTU; a_i = 32'd5; b_i = 32'd6;
      @(negedge clk);
      start_i = 1'b0;
      check("restart_busy", busy_o, 1);
      wait_done(nb);
      check("restart_lo", lo_o, 32'd30);
      check("restart_hi", hi_o, 0);

      pulse(OP_MTHI, 0, 0);
      pulse(OP_MTLO, 32'hFFFF_FFFF, 0);
`ifdef MULDIV_MADD_EN
      do_op(OP_MADD, 1, 1, nb);
      check("madd_lat", nb, L);
      check("madd_hi", hi_o, 1);
      check("madd_lo", lo_o, 0);
      do_op(OP_MSUB, 2, 3, nb);
      check("msub_hi", hi_o, 0);
      check("msub_lo", lo_o, 32'hFFFF_FFFA);
`else
      pulse(OP_MADD, 1, 1);
      check("madd_off_busy", busy_o, 0);
      repeat (3) @(negedge clk);
      check("madd_off_hi", hi_o, 0);
      check("madd_off_lo", lo_o, 32'hFFFF_FFFF);
      pulse(OP_MSUB, 1, 1);
      check("msub_off_busy", busy_o, 0);
`endif

      pulse(OP_DIV, 32'd50, 32'd7);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("async_rst_busy", busy_o, 0);
      check("async_rst_done", done_o, 0);
      check("async_rst_hi", hi_o, 0);
      check("async_rst_lo", lo_o, 0);
      @(negedge clk);
      rst = 1'b1;
      pulse(OP_MTHI, 32'h55, 0);
      check("post_rst_start_ignored", hi_o, 0);
      repeat (2) @(negedge clk);
      do_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, nb);
      check("post_rst_lat", nb, L);
      check("post_rst_hi", hi_o, 32'hFFFF_FFFF);
      check("post_rst_lo", lo_o, 32'hFFFF_FFFA);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
